// File: rtl/ysyx_25040109_ifu_pkg.sv
// Shared constants and helpers for the buffered instruction-fetch unit.
package ysyx_25040109_ifu_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned PC_INC       = 4;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ysyx_25040109_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push/pop/flush.
// Head data reads as zero while empty. DEPTH must be a power of two.
module ysyx_25040109_sync_fifo
  import ysyx_25040109_ifu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = cnt_width(DEPTH),
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ysyx_25040109_ifu_fetchq.sv
// Buffered instruction-fetch unit: owns the fetch PC, issues credit-limited
// in-order requests, queues responses with their PCs and hands them to the IDU.
// Optional zero-latency empty-queue bypass: define YSYX_25040109_IFU_BYPASS_EN.
module ysyx_25040109_ifu_fetchq
  import ysyx_25040109_ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            mem_resp_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            idu_ready,
  output logic            ifu_valid_to_idu,
  output logic [XLEN-1:0] inst_ifu,
  output logic [XLEN-1:0] pc_ifu
);

  localparam int unsigned     CW      = cnt_width(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;

  logic [CW-1:0]     q_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0]   head_inst;
  logic [XLEN-1:0]   head_pc;

  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              resp_fire;
  logic              resp_keep;

  assign mem_resp_ready = 1'b1;
  assign mem_req_addr   = fetch_pc;
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding};
  assign req_fire       = mem_req_valid && mem_req_ready;
  assign resp_fire      = mem_resp_valid;
  assign resp_keep      = resp_fire && (drop == '0) && !redirect_valid;
  assign head_inst      = fifo_head[2*XLEN-1:XLEN];
  assign head_pc        = fifo_head[XLEN-1:0];

  // Request only while credit remains and the back end is not redirecting.
  always_comb begin
    mem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  end

  // IDU handshake and queue control; redirect suppresses both push and pop.
  always_comb begin
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    ifu_valid_to_idu = 1'b0;
    inst_ifu         = head_inst;
    pc_ifu           = head_pc;
`ifdef YSYX_25040109_IFU_BYPASS_EN
    if (fifo_empty && resp_keep) begin
      ifu_valid_to_idu = 1'b1;
      inst_ifu         = mem_resp_rdata;
      pc_ifu           = resp_pc;
      fifo_push        = !idu_ready;
    end else begin
      ifu_valid_to_idu = !fifo_empty && !redirect_valid;
      fifo_pop         = ifu_valid_to_idu && idu_ready;
      fifo_push        = resp_keep && !fifo_full;
    end
`else
    ifu_valid_to_idu = !fifo_empty && !redirect_valid;
    fifo_pop         = ifu_valid_to_idu && idu_ready;
    fifo_push        = resp_keep && !fifo_full;
`endif
  end

  // PC, in-flight and discard counters. On redirect every response still in
  // flight (including one firing this cycle) must be discarded, so drop is
  // reloaded from outstanding rather than accumulated.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop     <= outstanding - CW'(resp_fire);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
        if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
        if (resp_fire && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  ysyx_25040109_sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata ({mem_resp_rdata, resp_pc}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

endmodule

// File: tb/tb_ysyx_25040109_ifu_fetchq.sv
// Directed self-checking bench for ysyx_25040109_ifu_fetchq (DEPTH=4, XLEN=32).
// Memory model returns one response per cycle, one cycle after the request,
// with data derived from the address. Inputs change at negedge, outputs are
// checked 3 time units later.
module tb_ysyx_25040109_ifu_fetchq;

`ifdef YSYX_25040109_IFU_BYPASS_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 2;
`endif

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        idu_ready;
  logic        ifu_valid_to_idu;
  logic [31:0] inst_ifu;
  logic [31:0] pc_ifu;

  logic        mem_stall;
  logic [31:0] mq[$];
  int          tests;
  int          fails;

  ysyx_25040109_ifu_fetchq #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rdata   (mem_resp_rdata),
    .mem_resp_ready   (mem_resp_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .idu_ready        (idu_ready),
    .ifu_valid_to_idu (ifu_valid_to_idu),
    .inst_ifu         (inst_ifu),
    .pc_ifu           (pc_ifu)
  );

  function automatic logic [31:0] minst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0013_0093;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // In-order memory: drives head response at negedge+1, records fires at +2.
  initial begin
    logic        rf, qf, r;
    logic [31:0] a;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_stall && mq.size() > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = minst(mq[0]);
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
      end
      #1;
      rf = mem_resp_valid;
      qf = mem_req_valid && mem_req_ready;
      a  = mem_req_addr;
      r  = rst;
      @(posedge clk);
      if (r) mq.delete();
      else begin
        if (rf) void'(mq.pop_front());
        if (qf) mq.push_back(a);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    idu_ready = 1'b0; mem_req_ready = 1'b1; mem_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    tests++;
    if (mem_req_valid !== 1'b0 || ifu_valid_to_idu !== 1'b0 || inst_ifu !== 32'h0 ||
        pc_ifu !== 32'h0 || mem_resp_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs: got req_v=%b v=%b inst=%h pc=%h rr=%b expected 0 0 0 0 1",
               mem_req_valid, ifu_valid_to_idu, inst_ifu, pc_ifu, mem_resp_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL first_request: got v=%b addr=%h expected 1 80000000", mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, exp_pc;
    do_reset();
    idu_ready = 1'b1;
    exp_req = 32'h8000_0000;
    exp_pc  = 32'h8000_0000;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      tests++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_req) begin
        fails++;
        $display("FAIL stream_req[%0d]: got v=%b addr=%h expected 1 %h", i, mem_req_valid, mem_req_addr, exp_req);
      end
      exp_req += 32'd4;
      if (i >= FIRST) begin
        tests++;
        if (ifu_valid_to_idu !== 1'b1 || pc_ifu !== exp_pc || inst_ifu !== minst(exp_pc)) begin
          fails++;
          $display("FAIL stream_idu[%0d]: got v=%b pc=%h inst=%h expected 1 %h %h",
                   i, ifu_valid_to_idu, pc_ifu, inst_ifu, exp_pc, minst(exp_pc));
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    logic [31:0] exp_pc;
    do_reset();
    idu_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      if (mem_req_valid === 1'b1) nreq++;
    end
    tests++;
    if (nreq != 4 || mem_req_valid !== 1'b0 || ifu_valid_to_idu !== 1'b1 || pc_ifu !== 32'h8000_0000) begin
      fails++;
      $display("FAIL bp_stall: got nreq=%0d req_v=%b v=%b pc=%h expected 4 0 1 80000000",
               nreq, mem_req_valid, ifu_valid_to_idu, pc_ifu);
    end
    @(negedge clk);
    idu_ready = 1'b1;
    exp_pc = 32'h8000_0000;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      #3;
      tests++;
      if (ifu_valid_to_idu !== 1'b1 || pc_ifu !== exp_pc || inst_ifu !== minst(exp_pc)) begin
        fails++;
        $display("FAIL bp_drain[%0d]: got v=%b pc=%h inst=%h expected 1 %h %h",
                 j, ifu_valid_to_idu, pc_ifu, inst_ifu, exp_pc, minst(exp_pc));
      end
      exp_pc += 32'd4;
      if (j == 1) begin
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010) begin
          fails++;
          $display("FAIL bp_resume: got v=%b addr=%h expected 1 80000010", mem_req_valid, mem_req_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit seen;
    do_reset();
    idu_ready = 1'b1;
    mem_stall = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    #3;
    tests++;
    if (mem_req_valid !== 1'b0 || ifu_valid_to_idu !== 1'b0) begin
      fails++;
      $display("FAIL redir_cycle: got req_v=%b v=%b expected 0 0", mem_req_valid, ifu_valid_to_idu);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    #3;
    tests++;
    if (ifu_valid_to_idu !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1000) begin
      fails++;
      $display("FAIL redir_after: got v=%b req_v=%b addr=%h expected 0 1 80001000",
               ifu_valid_to_idu, mem_req_valid, mem_req_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (ifu_valid_to_idu === 1'b1) begin
        seen = 1'b1;
        tests++;
        if (pc_ifu !== 32'h8000_1000 || inst_ifu !== minst(32'h8000_1000)) begin
          fails++;
          $display("FAIL redir_first: got pc=%h inst=%h expected 80001000 %h",
                   pc_ifu, inst_ifu, minst(32'h8000_1000));
        end
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL redir_first: got no instruction within 12 cycles expected pc 80001000");
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit seen;
    do_reset();
    idu_ready = 1'b1;
    mem_stall = 1'b1;
    repeat (2) @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    mem_stall      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    #3;
    tests++;
    if (mem_resp_valid !== 1'b1 || ifu_valid_to_idu !== 1'b0) begin
      fails++;
      $display("FAIL same_redir_cycle: got resp_v=%b v=%b expected 1 0", mem_resp_valid, ifu_valid_to_idu);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #3;
    tests++;
    if (dut.drop !== 3'd1 || mem_req_addr !== 32'h8000_2000) begin
      fails++;
      $display("FAIL same_drop: got drop=%0d addr=%h expected 1 80002000", dut.drop, mem_req_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (ifu_valid_to_idu === 1'b1) begin
        seen = 1'b1;
        tests++;
        if (pc_ifu !== 32'h8000_2000 || inst_ifu !== minst(32'h8000_2000)) begin
          fails++;
          $display("FAIL same_first: got pc=%h inst=%h expected 80002000 %h",
                   pc_ifu, inst_ifu, minst(32'h8000_2000));
        end
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL same_first: got no instruction within 10 cycles expected pc 80002000");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_req, exp_pc;
    int          nseen;
    do_reset();
    idu_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    exp_req = 32'hFFFF_FFF8;
    exp_pc  = 32'hFFFF_FFF8;
    nseen   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      if (i < 3) begin
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_req) begin
          fails++;
          $display("FAIL wrap_req[%0d]: got v=%b addr=%h expected 1 %h", i, mem_req_valid, mem_req_addr, exp_req);
        end
        exp_req += 32'd4;
      end
      if (ifu_valid_to_idu === 1'b1 && nseen < 3) begin
        tests++;
        if (pc_ifu !== exp_pc || inst_ifu !== minst(exp_pc)) begin
          fails++;
          $display("FAIL wrap_idu[%0d]: got pc=%h inst=%h expected %h %h", nseen, pc_ifu, inst_ifu, exp_pc, minst(exp_pc));
        end
        exp_pc += 32'd4;
        nseen++;
      end
    end
    tests++;
    if (nseen != 3) begin
      fails++;
      $display("FAIL wrap_count: got %0d instructions expected 3", nseen);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idu_ready = 1'b0;
    repeat (2) @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #3;
    tests++;
    if (ifu_valid_to_idu !== 1'b1 || pc_ifu !== 32'h8000_0000) begin
      fails++;
      $display("FAIL rstmid_pre: got v=%b pc=%h expected 1 80000000", ifu_valid_to_idu, pc_ifu);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    #3;
    tests++;
    if (ifu_valid_to_idu !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL rstmid_post: got v=%b req_v=%b addr=%h expected 0 1 80000000",
               ifu_valid_to_idu, mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_latency();
    do_reset();
    idu_ready = 1'b1;
    #3;
    tests++;
    if (ifu_valid_to_idu !== 1'b0) begin
      fails++;
      $display("FAIL lat_c0: got v=%b expected 0", ifu_valid_to_idu);
    end
    @(negedge clk);
    #3;
    tests++;
`ifdef YSYX_25040109_IFU_BYPASS_EN
    if (ifu_valid_to_idu !== 1'b1 || pc_ifu !== 32'h8000_0000 || inst_ifu !== minst(32'h8000_0000)) begin
      fails++;
      $display("FAIL lat_bypass: got v=%b pc=%h inst=%h expected 1 80000000 %h",
               ifu_valid_to_idu, pc_ifu, inst_ifu, minst(32'h8000_0000));
    end
`else
    if (ifu_valid_to_idu !== 1'b0) begin
      fails++;
      $display("FAIL lat_c1: got v=%b expected 0", ifu_valid_to_idu);
    end
`endif
    @(negedge clk);
    #3;
    tests++;
`ifdef YSYX_25040109_IFU_BYPASS_EN
    if (ifu_valid_to_idu !== 1'b1 || pc_ifu !== 32'h8000_0004) begin
      fails++;
      $display("FAIL lat_c2: got v=%b pc=%h expected 1 80000004", ifu_valid_to_idu, pc_ifu);
    end
`else
    if (ifu_valid_to_idu !== 1'b1 || pc_ifu !== 32'h8000_0000 || inst_ifu !== minst(32'h8000_0000)) begin
      fails++;
      $display("FAIL lat_c2: got v=%b pc=%h inst=%h expected 1 80000000 %h",
               ifu_valid_to_idu, pc_ifu, inst_ifu, minst(32'h8000_0000));
    end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    mem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    idu_ready = 1'b0;
    mem_stall = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
